pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). Drives the stall and flush inputs of the four pipeline_register instances (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write-enable. Resolves load-use hazards, taken branches, multi-cycle data-memory accesses and HLT drain. Pipeline registers output all-zero (a NOP bubble) while stalled; this block relies on that to insert bubbles.

---
 rtl/hazard_pkg.sv | 7 +
 rtl/hazard_detect.sv | 12 +
 rtl/pipeline_hazard_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: opcode, FSM state and default timing constants for pipeline_hazard_ctrl
package hazard_pkg;
  localparam logic [3:0] LW = 4'h8, SW = 4'h9, B = 4'hC, BR = 4'hD, HLT = 4'hF;
  localparam logic [2:0] RUN = 3'd0, MEM_WAIT = 3'd1, FLUSH = 3'd2, DRAIN = 3'd3, HALTED = 3'd4;
  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int DRAIN_CYCLES_DEF = 3;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare (ex_opcode, ex_rd, id_rs, id_rt -> load_use); R0 never hazards
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [3:0] ex_opcode,
  input  logic [3:0] ex_rd,
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  output logic       load_use
);
  assign load_use = (ex_opcode == LW) && (ex_rd != 4'd0) && (ex_rd == id_rs || ex_rd == id_rt);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage stall/flush sequencer (in: clk rst id_* ex_* branch_taken mem_req mem_ready; out: pc_wen *_stall *_flush halted err_timeout; HAZARD_PERF_CNT_EN adds stall_cycles/flush_count)
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_opcode,
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic [3:0] ex_opcode,
  input  logic [3:0] ex_rd,
  input  logic       branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_wen,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       ex_mem_stall,
  output logic       mem_wb_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       halted,
  output logic       err_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);
  logic [2:0] r_state, w_next;
  logic [3:0] r_wait_cnt, r_drain_cnt;
  logic       r_dwait, r_err;
  logic       w_load_use, w_taken, w_run, w_mem_start, w_mem_hold, w_mem_stall;
  logic       w_flush_br, w_halt_ex, w_lu, w_drain, w_halted, w_unused;
  hazard_detect u_detect (
    .ex_opcode(ex_opcode),
    .ex_rd    (ex_rd),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .load_use (w_load_use)
  );
  assign w_unused = ^id_opcode;
  assign w_taken  = (ex_opcode == B || ex_opcode == BR) && branch_taken;
  assign w_halted = r_state == HALTED;
  // The instruction frozen in EX leaves on the mem_ready edge, so its branch/HLT/load-use must be acted on in that cycle
  assign w_run       = r_state == RUN || (r_state == MEM_WAIT && mem_ready);
  // Inside DRAIN, r_dwait remembers an outstanding access so drain_cnt stays frozen until mem_ready
  assign w_mem_start = (w_run || (r_state == DRAIN && !r_dwait)) && mem_req && !mem_ready;
  assign w_mem_hold  = (r_state == MEM_WAIT || r_dwait) && !mem_ready;
  assign w_mem_stall = w_mem_start || w_mem_hold;
  assign w_flush_br  = w_run && !w_mem_stall && w_taken;
  assign w_halt_ex   = w_run && !w_mem_stall && !w_taken && ex_opcode == HLT;
  assign w_lu        = w_run && !w_mem_stall && !w_taken && ex_opcode != HLT && w_load_use;
  assign w_drain     = r_state == DRAIN && !w_mem_stall;
  assign ex_mem_stall = w_mem_stall || w_halted;
  assign mem_wb_stall = w_mem_stall || w_halted;
  assign if_id_stall  = w_mem_stall || w_halted || w_lu;
  assign id_ex_stall  = w_mem_stall || w_halted || w_lu;
  assign if_id_flush  = w_flush_br || w_halt_ex || w_drain;
  assign id_ex_flush  = w_flush_br || w_halt_ex;
  assign pc_wen       = !(w_mem_stall || w_halted || w_halt_ex || w_lu || r_state == DRAIN);
  assign halted       = w_halted;
  assign err_timeout  = r_err;
  assign w_next = (w_run && w_mem_stall)                  ? MEM_WAIT :
                  w_flush_br                              ? FLUSH    :
                  w_halt_ex                               ? DRAIN    :
                  (w_run || r_state == FLUSH)             ? RUN      :
                  (w_drain && r_drain_cnt == 4'd0)        ? HALTED   : r_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= 4'd0;
      r_drain_cnt <= 4'd0;
      r_dwait     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dwait <= r_state == DRAIN && w_mem_stall;
      if (w_mem_start) r_wait_cnt <= 4'd1;
      else if (w_mem_hold) begin
        if (r_wait_cnt == 4'(MEM_TIMEOUT)) r_err <= 1'b1;
        if (r_wait_cnt != 4'hF) r_wait_cnt <= r_wait_cnt + 4'd1;
      end
      if (w_halt_ex) r_drain_cnt <= 4'(DRAIN_CYCLES - 1);
      else if (w_drain && r_drain_cnt != 4'd0) r_drain_cnt <= r_drain_cnt - 4'd1;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 16'd0;
    end else begin
      if (!pc_wen && !w_halted && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush_br && r_flush_count != '1) r_flush_count <= r_flush_count + 16'd1;
    end
  end
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif
endmodule
